disp_pixel_fifo: RTL and testbench
==================================

DISP_PIXEL_FIFO -- requirements
Module: disp_pixel_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO depth in pixels; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have parameter UF_COLOR, default 24'h000000, giving the pixel value output on underflow and after flush.
REQ-003 The block SHALL have port Clk, input, 1 bit: the pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Pix_Data, input, 24 bits: upstream pixel, RGB888, with R in bits [23:16].
REQ-006 The block SHALL have port Pix_Valid, input, 1 bit: Pix_Data is valid.
REQ-007 The block SHALL have port Pix_Ready, output, 1 bit: the FIFO accepts a pixel this cycle.
REQ-008 The block SHALL have port Data_Req, input, 1 bit: the timing controller's pixel request, which leads its blanking-valid signal by one cycle.
REQ-009 The block SHALL have port Frame_Start, input, 1 bit: one-cycle pulse at frame start that flushes the FIFO.
REQ-010 The block SHALL have port DATA, output, 24 bits: the registered pixel sent to the timing controller's data input.
REQ-011 The block SHALL have port Level, output, clog2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-012 The block SHALL have port Underflow, output, 1 bit: sticky flag, set when a request hits an empty FIFO.
REQ-013 The block SHALL have port Underflow_Cnt, output, 16 bits; this port exists only when the macro in REQ-029 is defined.

Function
REQ-014 Pix_Ready SHALL equal (Level != DEPTH), decoded combinationally from the registered occupancy.
REQ-015 A write SHALL occur when Pix_Valid && Pix_Ready: Pix_Data is stored at the write pointer, and the write pointer advances modulo DEPTH.
REQ-016 A pop SHALL occur when Data_Req && (Level != 0): DATA loads the word at the read pointer on the next edge (one-cycle latency), and the read pointer advances modulo DEPTH.
REQ-017 An underflow read SHALL occur when Data_Req && (Level == 0): DATA loads UF_COLOR, Underflow is set to 1, and no pointer moves.
REQ-018 When Data_Req is 0, DATA SHALL hold its previous value.
REQ-019 Level SHALL update as Level + write - pop; a simultaneous write and pop leaves Level unchanged.
REQ-020 A pixel written into an empty FIFO SHALL NOT be visible to a Data_Req in the same cycle (no bypass); that request is an underflow.
REQ-021 When the FIFO is full, a simultaneous pop SHALL NOT enable a same-cycle write, because Pix_Ready follows the pre-pop Level.
REQ-022 Frame_Start SHALL reset both pointers and Level to 0, load DATA with UF_COLOR, and clear Underflow.
REQ-023 Frame_Start SHALL take precedence over a write and a request in the same cycle; both are discarded and Underflow is not set.
REQ-024 Pointers SHALL be clog2(DEPTH) bits and wrap naturally; Level SHALL never exceed DEPTH.
REQ-025 Storage SHALL be an inferred array with a synchronous write port and a registered read into DATA.

Reset
REQ-026 On Reset = 1 at a clock edge, the block SHALL set both pointers to 0, Level to 0, DATA to UF_COLOR, Underflow to 0, and Underflow_Cnt to 0.
REQ-027 Reset SHALL take precedence over Frame_Start, writes, and requests.
REQ-028 Array contents need not be reset; no read returns stale data because Level is 0 after reset.

Configuration
REQ-029 Macro PIX_UNDERFLOW_CNT_EN SHALL control the underflow counter.
  - Defined: Underflow_Cnt increments by 1 on each underflow read, saturates at 16'hFFFF, is cleared only by Reset, and is not cleared by Frame_Start.
  - Undefined: the Underflow_Cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-030 Write pixels 1..4 with Data_Req held low, then pulse Data_Req for 4 cycles -> DATA is 1,2,3,4 on the cycles after each request, Level goes 4->0, and Underflow stays 0.
REQ-031 Write continuously with DEPTH=16 and no requests -> Pix_Ready falls after the 16th accepted pixel, Level=16, and the 17th pixel is held by upstream rather than lost.
REQ-032 Issue Data_Req on an empty FIFO with a same-cycle write of 24'h00FF00 -> next DATA=UF_COLOR, Underflow=1, Level=1; the following request returns 24'h00FF00.
REQ-033 With the FIFO full, apply a request and a valid write in the same cycle -> Level goes 16->15 and the write is not accepted; the next cycle, the write is accepted and Level returns to 16.
REQ-034 Fill 5 pixels with Underflow=1, then pulse Frame_Start together with Data_Req -> Level=0, DATA=UF_COLOR, Underflow=0, and Underflow_Cnt is unchanged.
REQ-035 With PIX_UNDERFLOW_CNT_EN defined, issue 3 underflow requests and then assert Reset mid-stream -> Underflow_Cnt reads 3 before Reset, and after Reset all outputs match REQ-026.

Source files
------------

// File: rtl/disp_pixel_fifo.sv
// disp_pixel_fifo: pixel elastic buffer between an upstream pixel source and a
// display timing controller. Upstream writes with a valid/ready handshake; the
// timing controller pulls pixels with Data_Req and receives them on DATA one
// cycle later. Empty-FIFO requests return UF_COLOR and raise a sticky flag.
// Frame_Start flushes the buffer at each frame boundary.
// Optional feature: define PIX_UNDERFLOW_CNT_EN to add the saturating 16-bit
// Underflow_Cnt output that counts underflow reads (cleared only by Reset).
module disp_pixel_fifo #(
    parameter int          DEPTH    = 16,
    parameter logic [23:0] UF_COLOR = 24'h000000
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [23:0]                Pix_Data,
    input  logic                       Pix_Valid,
    output logic                       Pix_Ready,
    input  logic                       Data_Req,
    input  logic                       Frame_Start,
    output logic [23:0]                DATA,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       Underflow
`ifdef PIX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                Underflow_Cnt
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [23:0]   r_data;
    logic          r_underflow;

    logic          w_ready;
    logic          w_empty;
    logic          w_wr;
    logic          w_pop;
    logic          w_uf_read;

    // Ready comes from the registered occupancy only, so a same-cycle pop on a
    // full FIFO cannot open a write slot.
    assign w_ready   = (r_level != FULL_LVL);
    assign w_empty   = (r_level == '0);
    // Frame_Start discards any same-cycle write or request.
    assign w_wr      = Pix_Valid && w_ready && !Frame_Start;
    assign w_pop     = Data_Req && !w_empty && !Frame_Start;
    assign w_uf_read = Data_Req && w_empty && !Frame_Start;

    assign Pix_Ready = w_ready;
    assign DATA      = r_data;
    assign Level     = r_level;
    assign Underflow = r_underflow;

    // Storage write port; contents are never reset because Level guards reads.
    always_ff @(posedge Clk) begin
        if (!Reset && w_wr) begin
            r_mem[r_wr_ptr] <= Pix_Data;
        end
    end

    // Registered read into DATA: popped word, UF_COLOR on underflow/flush, else hold.
    always_ff @(posedge Clk) begin
        if (Reset || Frame_Start || w_uf_read) begin
            r_data <= UF_COLOR;
        end else if (w_pop) begin
            r_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clk) begin
        if (Reset || Frame_Start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky underflow flag, cleared by reset or frame flush.
    always_ff @(posedge Clk) begin
        if (Reset || Frame_Start) begin
            r_underflow <= 1'b0;
        end else if (w_uf_read) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef PIX_UNDERFLOW_CNT_EN
    logic [15:0] r_uf_cnt;

    // Saturating underflow counter; survives Frame_Start, cleared only by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_uf_cnt <= '0;
        end else if (w_uf_read && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign Underflow_Cnt = r_uf_cnt;
`endif

endmodule

// File: tb/tb_disp_pixel_fifo.sv
// tb_disp_pixel_fifo: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the pixel FIFO.
module tb_disp_pixel_fifo;

    localparam int          DEPTH = 16;
    localparam logic [23:0] UF    = 24'hA5C35A;
    localparam int          LW    = $clog2(DEPTH) + 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [23:0]   Pix_Data;
    logic          Pix_Valid;
    logic          Pix_Ready;
    logic          Data_Req;
    logic          Frame_Start;
    logic [23:0]   DATA;
    logic [LW-1:0] Level;
    logic          Underflow;
`ifdef PIX_UNDERFLOW_CNT_EN
    logic [15:0]   Underflow_Cnt;
`endif

    disp_pixel_fifo #(.DEPTH(DEPTH), .UF_COLOR(UF)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Pix_Data    (Pix_Data),
        .Pix_Valid   (Pix_Valid),
        .Pix_Ready   (Pix_Ready),
        .Data_Req    (Data_Req),
        .Frame_Start (Frame_Start),
        .DATA        (DATA),
        .Level       (Level),
        .Underflow   (Underflow)
`ifdef PIX_UNDERFLOW_CNT_EN
        ,
        .Underflow_Cnt (Underflow_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [23:0] m_q[$];
    logic [23:0] m_data;
    logic        m_uf;
    int          m_cnt;
    logic        m_accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model one clock edge from the specification's rules.
    task automatic model_step(input logic v, input logic [23:0] d, input logic req,
                              input logic fs, input logic rst);
        bit ready_pre;
        ready_pre  = (m_q.size() != DEPTH);
        m_accepted = 1'b0;
        if (rst) begin
            m_q.delete();
            m_data = UF;
            m_uf   = 1'b0;
            m_cnt  = 0;
        end else if (fs) begin
            m_q.delete();
            m_data = UF;
            m_uf   = 1'b0;
        end else begin
            if (req) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                end else begin
                    m_data = UF;
                    m_uf   = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (v && ready_pre) begin
                m_q.push_back(d);
                m_accepted = 1'b1;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs 1 ns after the edge.
    task automatic cycle(input logic v, input logic [23:0] d, input logic req,
                         input logic fs, input logic rst);
        Pix_Valid   = v;
        Pix_Data    = d;
        Data_Req    = req;
        Frame_Start = fs;
        Reset       = rst;
        @(posedge Clk);
        model_step(v, d, req, fs, rst);
        #1;
        chk("DATA",      32'(DATA),      32'(m_data));
        chk("Level",     32'(Level),     32'(m_q.size()));
        chk("Underflow", 32'(Underflow), 32'(m_uf));
        chk("Pix_Ready", 32'(Pix_Ready), 32'(m_q.size() != DEPTH));
`ifdef PIX_UNDERFLOW_CNT_EN
        chk("Underflow_Cnt", 32'(Underflow_Cnt), 32'(m_cnt));
`endif
        $display("cyc v=%0b d=%06h req=%0b fs=%0b rst=%0b -> DATA=%06h Level=%0d UF=%0b Rdy=%0b",
                 v, d, req, fs, rst, DATA, Level, Underflow, Pix_Ready);
    endtask

    initial begin
        Reset = 1'b1; Pix_Valid = 1'b0; Pix_Data = '0; Data_Req = 1'b0; Frame_Start = 1'b0;
        m_data = UF; m_uf = 1'b0; m_cnt = 0; m_accepted = 1'b0;
        @(negedge Clk);

        // Reset state
        cycle(0, 24'h0, 0, 0, 1);
        cycle(0, 24'h0, 0, 0, 1);
        chk("rst_DATA", 32'(DATA), 32'(UF));
        chk("rst_Level", 32'(Level), 32'd0);
        chk("rst_Ready", 32'(Pix_Ready), 32'd1);

        // Write 1..4, then read them back in order
        for (int i = 1; i <= 4; i++) cycle(1, 24'(i), 0, 0, 0);
        chk("fill4_Level", 32'(Level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 24'h0, 1, 0, 0);
            chk("read_DATA", 32'(DATA), 32'(i));
            chk("read_Level", 32'(Level), 32'(4 - i));
        end
        chk("read_Underflow", 32'(Underflow), 32'd0);

        // Empty-FIFO request with same-cycle write: no bypass
        cycle(1, 24'h00FF00, 1, 0, 0);
        chk("nobypass_DATA", 32'(DATA), 32'(UF));
        chk("nobypass_UF", 32'(Underflow), 32'd1);
        chk("nobypass_Level", 32'(Level), 32'd1);
        cycle(0, 24'h0, 1, 0, 0);
        chk("nobypass_next", 32'(DATA), 32'h00FF00);

        // Fill to full; 17th pixel is held back by Pix_Ready
        cycle(0, 24'h0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 24'h100 + 24'(i), 0, 0, 0);
        chk("full_Level", 32'(Level), 32'(DEPTH));
        chk("full_Ready", 32'(Pix_Ready), 32'd0);
        cycle(1, 24'h111111, 0, 0, 0);
        chk("full_hold", 32'(Level), 32'(DEPTH));

        // Full: simultaneous pop and write -> write refused this cycle, accepted next
        cycle(1, 24'h222222, 1, 0, 0);
        chk("fullpop_Level", 32'(Level), 32'(DEPTH - 1));
        chk("fullpop_DATA", 32'(DATA), 32'h100);
        cycle(1, 24'h222222, 0, 0, 0);
        chk("fullpop_refill", 32'(Level), 32'(DEPTH));

        // Flush with Underflow set and a concurrent request
        cycle(0, 24'h0, 0, 1, 0);
        cycle(0, 24'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 24'h300 + 24'(i), 0, 0, 0);
        chk("preflush_UF", 32'(Underflow), 32'd1);
        cycle(1, 24'h333333, 1, 1, 0);
        chk("flush_Level", 32'(Level), 32'd0);
        chk("flush_DATA", 32'(DATA), 32'(UF));
        chk("flush_UF", 32'(Underflow), 32'd0);

`ifdef PIX_UNDERFLOW_CNT_EN
        // Counter: 3 underflows then reset mid-stream
        cycle(0, 24'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 24'h0, 1, 0, 0);
        chk("cnt_3", 32'(Underflow_Cnt), 32'd3);
        cycle(0, 24'h0, 1, 1, 0);
        chk("cnt_fs_keep", 32'(Underflow_Cnt), 32'd3);
        cycle(1, 24'h444444, 1, 1, 1);
        chk("cnt_rst", 32'(Underflow_Cnt), 32'd0);
        chk("cnt_rst_DATA", 32'(DATA), 32'(UF));
`endif

        // Randomized traffic: write-heavy, balanced, then read-heavy phases
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 250; n++) begin
                logic v, r, f;
                v = ($urandom_range(0, 9) < (ph == 0 ? 8 : (ph == 1 ? 5 : 3)));
                r = ($urandom_range(0, 9) < (ph == 0 ? 3 : (ph == 1 ? 5 : 8)));
                f = ($urandom_range(0, 79) == 0);
                cycle(v, 24'($urandom), r, f, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
